// File: rtl/alu_acc_pkg.sv
// Shared types for the accumulator execution stage: opcodes, FSM states, default width.
package alu_acc_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LD  = 3'd1,
    OP_ST  = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_acc_alu.sv
// Combinational ALU for the accumulator stage.
// ALU_ACC_STAGE_SAT_EN: ADD clamps to all-ones on carry, SUB clamps to zero on borrow.
module alu_acc_alu
  import alu_acc_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  input  logic         carry_in,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  logic [W:0] sum;
  logic [W:0] diff;

  // The extra MSB of diff is the borrow, i.e. acc < operand.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result = acc;
    carry  = carry_in;
    case (op_e'(op))
      OP_LD:  result = operand;
      OP_ADD: begin
        {carry, result} = sum;
`ifdef ALU_ACC_STAGE_SAT_EN
        if (sum[W]) result = '1;
`endif
      end
      OP_SUB: begin
        {carry, result} = diff;
`ifdef ALU_ACC_STAGE_SAT_EN
        if (diff[W]) result = '0;
`endif
      end
      OP_AND: begin result = acc & operand; carry = 1'b0; end
      OP_OR:  begin result = acc | operand; carry = 1'b0; end
      OP_XOR: begin result = acc ^ operand; carry = 1'b0; end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_acc_stage.sv
// Accumulator execution stage: drives the register file, holds ACC and Z/C flags.
// Saturating ADD/SUB is enabled by defining ALU_ACC_STAGE_SAT_EN.
module alu_acc_stage
  import alu_acc_pkg::*;
#(
  parameter int REG_COUNT  = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            opcode,
  input  logic [AW-1:0]         op_addr,
  output logic [AW-1:0]         rf_addr,
  output logic                  rf_ce,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  done
);

  state_e                state;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_z;

  assign op_ready = (state == IDLE);
  assign rf_ce    = (state == WRITE);
  assign rf_wdata = acc;

  alu_acc_alu #(.W(DATA_WIDTH)) u_alu (
    .op       (op_q),
    .acc      (acc),
    .operand  (rf_rdata),
    .carry_in (flag_c),
    .result   (alu_res),
    .carry    (alu_c),
    .zero     (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_NOP;
      rf_addr <= '0;
      acc     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          op_q    <= opcode;
          rf_addr <= op_addr;
          case (op_e'(opcode))
            OP_NOP:  done  <= 1'b1;
            OP_ST:   state <= WRITE;
            default: state <= READ;
          endcase
        end
        READ: state <= EXEC;
        // Registered read data is valid here; only ACC-writing ops reach EXEC.
        EXEC: begin
          acc    <= alu_res;
          flag_z <= alu_z;
          flag_c <= alu_c;
          done   <= 1'b1;
          state  <= IDLE;
        end
        WRITE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_stage.sv
// Directed bench for alu_acc_stage with a registered-read register file model (R0..R3 = 2,3,4,5).
module tb_alu_acc_stage;
  import alu_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] opcode = 3'd0;
  logic [1:0] op_addr = 2'd0;
  logic [1:0] rf_addr;
  logic       rf_ce;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int ce_cnt = 0;
  logic [7:0] mem [4];

  always #5 clk = ~clk;

  alu_acc_stage #(.REG_COUNT(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_addr(op_addr), .rf_addr(rf_addr), .rf_ce(rf_ce),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .acc(acc),
    .flag_z(flag_z), .flag_c(flag_c), .done(done)
  );

  // Register file: contents return to 2,3,4,5 on reset, read data registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= 8'd2; mem[1] <= 8'd3; mem[2] <= 8'd4; mem[3] <= 8'd5;
      rf_rdata <= 8'd0;
    end else begin
      if (rf_ce) mem[rf_addr] <= rf_wdata;
      rf_rdata <= mem[rf_addr];
    end
  end

  always @(posedge clk) if (rst_n && rf_ce) ce_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accept edge with garbage on the op inputs.
  task automatic do_op(input op_e op, input logic [1:0] a);
    opcode = op; op_addr = a; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; opcode = 3'($urandom); op_addr = 2'($urandom);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
  endtask

  initial begin
    // Reset state
    wait_neg(2);
    check("rst_ready", op_ready, 1);
    check("rst_acc", acc, 0);
    check("rst_z", flag_z, 0);
    check("rst_c", flag_c, 0);
    check("rst_done", done, 0);
    check("rst_ce", rf_ce, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    wait_neg(1);

    // LD R1 with detailed timing
    do_op(OP_LD, 2'd1);
    wait_neg(1);
    check("ld_addr", rf_addr, 1);
    check("ld_ready_c1", op_ready, 0);
    check("ld_done_c1", done, 0);
    wait_neg(1);
    check("ld_ready_c2", op_ready, 0);
    check("ld_acc_c2", acc, 0);
    wait_neg(1);
    check("ld_acc", acc, 3);
    check("ld_z", flag_z, 0);
    check("ld_c", flag_c, 0);
    check("ld_done", done, 1);
    check("ld_ready_c3", op_ready, 1);

    // ADD R3 back-to-back in the DONE cycle
    do_op(OP_ADD, 2'd3);
    wait_neg(3);
    check("add_acc", acc, 8);
    check("add_c", flag_c, 0);
    check("add_done", done, 1);

    // ST R0
    do_op(OP_ST, 2'd0);
    wait_neg(1);
    check("st_ce", rf_ce, 1);
    check("st_addr", rf_addr, 0);
    check("st_wdata", rf_wdata, 8);
    check("st_done_c1", done, 0);
    wait_neg(1);
    check("st_ce_off", rf_ce, 0);
    check("st_done", done, 1);

    // LD R0 reads back the stored value
    do_op(OP_LD, 2'd0);
    wait_neg(3);
    check("ldr0_acc", acc, 8);

    // SUB borrow, NOP, then ADD carry
    do_reset();
    do_op(OP_LD, 2'd1);
    wait_neg(3);
    do_op(OP_SUB, 2'd2);
    wait_neg(3);
`ifdef ALU_ACC_STAGE_SAT_EN
    check("sub_acc", acc, 8'h00);
    check("sub_z", flag_z, 1);
`else
    check("sub_acc", acc, 8'hFF);
    check("sub_z", flag_z, 0);
`endif
    check("sub_c", flag_c, 1);
    do_op(OP_NOP, 2'd0);
    wait_neg(1);
    check("nop_done", done, 1);
    check("nop_c", flag_c, 1);
    wait_neg(1);
    check("nop_done_off", done, 0);
    do_op(OP_ADD, 2'd0);
    wait_neg(3);
`ifdef ALU_ACC_STAGE_SAT_EN
    check("addc_acc", acc, 8'h02);
    check("addc_c", flag_c, 0);
`else
    check("addc_acc", acc, 8'h01);
    check("addc_c", flag_c, 1);
`endif
    check("addc_z", flag_z, 0);

    // LD R1 with OP_VALID held (as ST) while busy, then XOR R1, then NOP
    do_reset();
    do_op(OP_LD, 2'd1);
    op_valid = 1'b1; opcode = OP_ST; op_addr = 2'd2;
    wait_neg(2);
    op_valid = 1'b0;
    wait_neg(1);
    check("hold_acc", acc, 3);
    check("hold_ce", rf_ce, 0);
    do_op(OP_XOR, 2'd1);
    wait_neg(3);
    check("xor_acc", acc, 0);
    check("xor_z", flag_z, 1);
    check("xor_c", flag_c, 0);
    do_op(OP_NOP, 2'd3);
    wait_neg(1);
    check("nop2_done", done, 1);
    check("nop2_acc", acc, 0);
    check("nop2_z", flag_z, 1);
    check("nop2_ready", op_ready, 1);

    // Reset during READ of ADD R3
    do_reset();
    do_op(OP_LD, 2'd1);
    wait_neg(3);
    do_op(OP_ADD, 2'd3);
    wait_neg(1);
    check("mid_ready_busy", op_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_acc", acc, 0);
    check("mid_ready", op_ready, 1);
    check("mid_z", flag_z, 0);
    check("mid_c", flag_c, 0);
    check("mid_addr", rf_addr, 0);
    wait_neg(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_neg(1);
      check("mid_no_done", done, 0);
      check("mid_acc_hold", acc, 0);
    end

    check("ce_total", ce_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_acc_stage.md
# alu_acc_stage

Accumulator execution stage that sits directly downstream of the register file. It accepts one operation at a time and drives the register-file address, write-enable and write data. It consumes the register file's registered read data, which arrives one cycle after the address. It also holds the 8-bit accumulator and the Z/C flags that the sequencer uses for branching.

## Interface
- REG_COUNT, 4, number of registers in the attached register file; sets address width AW = $clog2(REG_COUNT)
- DATA_WIDTH, 8, accumulator and register width
- CLK  in  1  system clock, rising edge
- RSTN  in  1  reset; asynchronous, active-low
- OP_VALID  in  1  operation request
- OP_READY  out  1  stage can accept; combinational, high only in IDLE
- OPCODE  in  3  operation (encoding below)
- OP_ADDR  in  AW  register operand index
- RF_ADDR  out  AW  register-file address; registered copy of the latched OP_ADDR
- RF_CE  out  1  register-file write enable
- RF_WDATA  out  DATA_WIDTH  register-file write data; always equals ACC
- RF_RDATA  in  DATA_WIDTH  register-file registered read data
- ACC  out  DATA_WIDTH  accumulator
- FLAG_Z  out  1  accumulator zero flag
- FLAG_C  out  1  carry/borrow flag
- DONE  out  1  one-cycle completion pulse

## Operation
- Opcodes: 0 NOP, 1 LD (ACC=R), 2 ST (R=ACC), 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR. All eight codes are legal.
- An operation is accepted on a rising edge with OP_VALID && OP_READY. OPCODE and OP_ADDR are latched at that edge; RF_ADDR takes OP_ADDR at the same edge.
- State machine transitions:
  - IDLE -> READ for LD/ADD/SUB/AND/OR/XOR.
  - IDLE -> WRITE for ST.
  - IDLE -> IDLE for NOP.
  - READ -> EXEC.
  - EXEC -> IDLE.
  - WRITE -> IDLE.
- READ: the register file samples RF_ADDR. No other action.
- EXEC: RF_RDATA is valid. ACC and flags update at the end of EXEC.
- WRITE: RF_CE=1 for exactly one cycle, with RF_WDATA=ACC.
- Arithmetic, with R = RF_RDATA:
  - ADD: {C,ACC} = ACC + R, computed DATA_WIDTH+1 wide.
  - SUB: ACC = ACC - R, wrapping modulo 2^DATA_WIDTH; C=1 iff ACC < R (borrow).
  - AND/OR/XOR: C=0.
  - LD: C unchanged.
- Z = (new ACC == 0) for every ACC-writing op. ST and NOP leave ACC, Z and C unchanged.
- DONE is registered. It is high for one cycle after the edge that leaves EXEC or WRITE, or after the edge accepting a NOP.
- A new op may be accepted in the same cycle DONE is high, so operations run back-to-back without bubbles beyond the FSM.
- RF_CE is never high outside WRITE. The stage never reads and writes the register file in the same cycle.

## Timing
- Reset values: state IDLE, OP_READY=1, ACC=0, FLAG_Z=0, FLAG_C=0, DONE=0, RF_CE=0, RF_ADDR=0. RF_WDATA=0 follows from ACC.
- Counting from the accept edge E0:
  - READ-path ops: ACC updates at E2; DONE is high in the cycle after E2.
  - ST: RF_CE is high in the cycle after E0; the register is written at E1; DONE is high in the cycle after E1.
  - NOP: DONE is high in the cycle after E0.
- OP_VALID held high while OP_READY=0 has no effect. OPCODE/OP_ADDR changes outside the accept edge are ignored.
- Reset asserted mid-operation (any state) aborts it immediately: no RF_CE, no ACC update, no DONE. All outputs return to reset values asynchronously.

## Configuration
- ALU_ACC_STAGE_SAT_EN defined: ADD clamps ACC to all-ones when the carry is 1, and SUB clamps ACC to 0 when the borrow is 1. C still reports the unclamped carry/borrow; Z reflects the clamped ACC.
- ALU_ACC_STAGE_SAT_EN undefined: ADD and SUB wrap as described in Operation. No clamp logic is present.

## Structure
- Shared package alu_acc_pkg holds:
  - typedef enum logic [2:0] op_e for the opcodes.
  - typedef enum state_e {IDLE, READ, EXEC, WRITE}.
  - localparam DATA_WIDTH_DEF = 8.
- Sub-module alu_acc_alu is purely combinational. Inputs: op, acc, operand, carry-in. Outputs: result, carry, zero. It contains the saturation option. The FSM and registers stay in alu_acc_stage.

## Test plan
All scenarios use the register file's reset contents R0=2, R1=3, R2=4, R3=5.
- Reset, then LD R1 -> RF_ADDR=1 at E0, ACC=3, Z=0, C=0 at E2, DONE one cycle after E2, OP_READY low for exactly two cycles.
- ACC=3, ADD R3 -> ACC=8, C=0. Then ST R0 -> RF_CE high one cycle with RF_ADDR=0, RF_WDATA=8. Then LD R0 -> ACC=8.
- ACC=3, SUB R2 -> ACC=0xFF, C=1, Z=0. With ALU_ACC_STAGE_SAT_EN -> ACC=0x00, C=1, Z=1.
- ACC=0xFF, ADD R0 -> ACC=0x01, C=1. With ALU_ACC_STAGE_SAT_EN -> ACC=0xFF, C=1.
- LD R1, XOR R1 -> ACC=0, Z=1, C=0. A following NOP leaves ACC/Z/C unchanged and pulses DONE one cycle after acceptance.
- RSTN pulsed low during READ of ADD R3, with ACC=3 -> ACC=0, flags 0, no DONE, RF_CE never high. OP_READY=1 immediately.
